// File: rtl/gpio_mon_pkg.sv
// Shared types and helpers for the GPIO pattern monitor.
package gpio_mon_pkg;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_PASS    = 2'd1,
    RES_FAIL    = 2'd2,
    RES_TIMEOUT = 2'd3
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned NPORTS_DEFAULT = 3;

  // Width of the fail_port index; a single port still needs one bit.
  function automatic int unsigned fail_port_w(input int unsigned nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

  localparam int unsigned FAIL_PORT_W_DEFAULT = fail_port_w(NPORTS_DEFAULT);

endpackage

// File: rtl/gpio_pattern_monitor_if.sv
// Control/status bundle between the monitor and whatever arms it.
interface gpio_pattern_monitor_if
  import gpio_mon_pkg::*;
#(
  parameter int unsigned NPORTS = 3,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned BW   = NPORTS * WIDTH;
  localparam int unsigned FP_W = fail_port_w(NPORTS);

  logic [BW-1:0]    port_in;
  logic             start;
  logic             abort;
  logic [BW-1:0]    pass_mask;
  logic [BW-1:0]    pass_value;
  logic [BW-1:0]    fail_mask;
  logic [BW-1:0]    fail_value;
  logic             busy;
  logic             done;
  logic             irq;
  result_e          result;
  logic [FP_W-1:0]  fail_port;
  logic [CNT_W-1:0] elapsed;

  modport master (
    output port_in, start, abort, pass_mask, pass_value, fail_mask, fail_value,
    input  busy, done, irq, result, fail_port, elapsed
  );

  modport slave (
    input  port_in, start, abort, pass_mask, pass_value, fail_mask, fail_value,
    output busy, done, irq, result, fail_port, elapsed
  );

endinterface

// File: rtl/gpio_mon_sync.sv
// Parametrised-width two-flop synchronizer for asynchronous pad inputs.
module gpio_mon_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_pattern_monitor.sv
// Watches NPORTS synchronized GPIO ports for a held pass pattern, a fail
// pattern or a timeout, and latches the verdict until restarted or aborted.
module gpio_pattern_monitor
  import gpio_mon_pkg::*;
#(
  parameter int unsigned NPORTS         = 3,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  gpio_pattern_monitor_if.slave bus
);

  localparam int unsigned BW   = NPORTS * WIDTH;
  localparam int unsigned FP_W = fail_port_w(NPORTS);
  localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

  logic [BW-1:0]    sync_q;
  logic [BW-1:0]    pass_mask_q;
  logic [BW-1:0]    pass_value_q;
  logic [BW-1:0]    fail_mask_q;
  logic [BW-1:0]    fail_value_q;
  state_e           state;
  logic [HC_W-1:0]  hold_cnt;
  logic [CNT_W-1:0] elapsed_q;
  result_e          result_q;
  logic [FP_W-1:0]  fail_port_q;
  logic             busy_q;
  logic             done_q;
  logic             irq_q;

  logic [NPORTS-1:0] pass_ok;
  logic [NPORTS-1:0] fail_hit;
  logic              pass_all;
  logic              fail_any;
  logic [FP_W-1:0]   fail_idx;
  logic [CNT_W-1:0]  elapsed_inc;
  logic              hold_last;
  logic              timeout_hit;

  gpio_mon_sync #(.W(BW)) u_sync (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .d     (bus.port_in),
    .q     (sync_q)
  );

  // Per-port compare against the patterns latched at start.
  for (genvar p = 0; p < int'(NPORTS); p++) begin : g_port
    logic [WIDTH-1:0] s_p;
    assign s_p         = sync_q[p*WIDTH +: WIDTH];
    assign pass_ok[p]  = ((s_p ^ pass_value_q[p*WIDTH +: WIDTH]) & pass_mask_q[p*WIDTH +: WIDTH]) == '0;
    assign fail_hit[p] = (fail_mask_q[p*WIDTH +: WIDTH] != '0) &&
                         (((s_p ^ fail_value_q[p*WIDTH +: WIDTH]) & fail_mask_q[p*WIDTH +: WIDTH]) == '0);
  end

  assign pass_all = &pass_ok;
  assign fail_any = |fail_hit;

  // Lowest failing port wins: scan from the top so the lowest index is written last.
  always_comb begin
    fail_idx = '0;
    for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
      if (fail_hit[i]) fail_idx = FP_W'(i);
    end
  end

  assign elapsed_inc = elapsed_q + CNT_W'(1);
  assign hold_last   = (32'(hold_cnt) + 32'd1) == 32'(HOLD_CYCLES);
  assign timeout_hit = elapsed_inc == CNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      elapsed_q    <= '0;
      result_q     <= RES_NONE;
      fail_port_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      pass_mask_q  <= '0;
      pass_value_q <= '0;
      fail_mask_q  <= '0;
      fail_value_q <= '0;
    end else begin
      irq_q <= 1'b0;
      if (bus.abort) begin
        state       <= ST_IDLE;
        hold_cnt    <= '0;
        elapsed_q   <= '0;
        result_q    <= RES_NONE;
        fail_port_q <= '0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              state        <= ST_ARMED;
              hold_cnt     <= '0;
              elapsed_q    <= '0;
              result_q     <= RES_NONE;
              fail_port_q  <= '0;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              pass_mask_q  <= bus.pass_mask;
              pass_value_q <= bus.pass_value;
              fail_mask_q  <= bus.fail_mask;
              fail_value_q <= bus.fail_value;
            end
          end
          ST_ARMED, ST_HOLD: begin
            elapsed_q <= elapsed_inc;
            if (fail_any || (pass_all && hold_last) || timeout_hit) begin
              state    <= ST_DONE;
              hold_cnt <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              irq_q    <= 1'b1;
              if (fail_any) begin
                result_q    <= RES_FAIL;
                fail_port_q <= fail_idx;
              end else if (pass_all && hold_last) begin
                result_q <= RES_PASS;
              end else begin
                result_q <= RES_TIMEOUT;
              end
            end else if (pass_all) begin
              hold_cnt <= hold_cnt + HC_W'(1);
              state    <= ST_HOLD;
            end else begin
              hold_cnt <= '0;
              state    <= ST_ARMED;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.irq       = irq_q;
  assign bus.result    = result_q;
  assign bus.fail_port = fail_port_q;
  assign bus.elapsed   = elapsed_q;

endmodule

// File: tb/tb_gpio_pattern_monitor.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized runs checked against a pin-history reference model.
module tb_gpio_pattern_monitor;
  import gpio_mon_pkg::*;

  localparam int unsigned NP   = 3;
  localparam int unsigned W    = 8;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned CW   = 16;
  localparam int unsigned BW   = NP * W;
  localparam int          LOGN = 4096;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  gpio_pattern_monitor_if #(.NPORTS(NP), .WIDTH(W), .CNT_W(CW)) bus ();

  gpio_pattern_monitor #(
    .NPORTS(NP), .WIDTH(W), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pin value present at each rising edge, indexed by absolute edge number.
  int            ecnt = 0;
  logic [BW-1:0] pin_log [LOGN];
  always @(posedge HCLK) begin
    pin_log[ecnt % LOGN] = bus.port_in;
    ecnt = ecnt + 1;
  end

  typedef struct {
    logic [BW-1:0] pm, pv, fm, fv, pins;
    result_e       res;
    int            fp;
    int            lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [BW-1:0] rnd_pins(input logic [BW-1:0] cur);
    logic [BW-1:0] v;
    v = cur;
    for (int p = 0; p < int'(NP); p++)
      if ($urandom_range(5) == 0) v[p*W +: W] = W'($urandom_range(3));
    return v;
  endfunction

  // Reference: the sample seen at evaluation edge e is the pin at edge e-2.
  task automatic model(input int s, input int last,
                       input logic [BW-1:0] pm, pv, fm, fv,
                       output result_e r, output int fp, output int ve);
    int run;
    r = RES_NONE; fp = 0; ve = -1; run = 0;
    for (int k = 1; k <= int'(TMO); k++) begin
      int            e;
      logic [BW-1:0] v;
      bit            pok;
      int            fidx;
      e = s + k;
      if (e > last) break;
      v = pin_log[(e - 2) % LOGN];
      pok = 1'b1; fidx = -1;
      for (int p = int'(NP) - 1; p >= 0; p--) begin
        logic [W-1:0] sp, pmp, pvp, fmp, fvp;
        sp = v[p*W +: W]; pmp = pm[p*W +: W]; pvp = pv[p*W +: W];
        fmp = fm[p*W +: W]; fvp = fv[p*W +: W];
        if (((sp ^ pvp) & pmp) != '0) pok = 1'b0;
        if (fmp != '0 && ((sp ^ fvp) & fmp) == '0) fidx = p;
      end
      run = pok ? run + 1 : 0;
      if (fidx >= 0)          begin r = RES_FAIL;    fp = fidx; ve = e; break; end
      if (run == int'(HOLD))  begin r = RES_PASS;    ve = e;    break; end
      if (k == int'(TMO))     begin r = RES_TIMEOUT; ve = e;    break; end
    end
  endtask

  task automatic do_start(input logic [BW-1:0] pm, pv, fm, fv, output int s);
    bus.pass_mask = pm; bus.pass_value = pv;
    bus.fail_mask = fm; bus.fail_value = fv;
    bus.start = 1'b1;
    s = ecnt;
    tick();
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for DONE, then compare verdict, timing and irq with the model.
  task automatic wait_check(input string nm, input int s,
                            input logic [BW-1:0] pm, pv, fm, fv,
                            input bit rnd, output int de);
    result_e er;
    int      efp, eve;
    de = -1;
    for (int n = 0; n < int'(TMO) + 20; n++) begin
      if (bus.done) begin de = ecnt - 1; break; end
      if (rnd) bus.port_in = rnd_pins(bus.port_in);
      tick();
    end
    if (de < 0) begin
      chk({nm, " done"}, 64'(bus.done), 64'd1);
      return;
    end
    model(s, de, pm, pv, fm, fv, er, efp, eve);
    chk({nm, " result"}, 64'(bus.result), 64'(er));
    chk({nm, " done_edge"}, 64'(de), 64'(eve));
    chk({nm, " elapsed"}, 64'(bus.elapsed), 64'(eve - s));
    if (er == RES_FAIL) chk({nm, " fail_port"}, 64'(bus.fail_port), 64'(efp));
    chk({nm, " irq"}, 64'(bus.irq), 64'd1);
    chk({nm, " busy"}, 64'(bus.busy), 64'd0);
    tick();
    chk({nm, " irq_drop"}, 64'(bus.irq), 64'd0);
    chk({nm, " done_hold"}, 64'(bus.done), 64'd1);
    chk({nm, " elapsed_frozen"}, 64'(bus.elapsed), 64'(eve - s));
  endtask

  vec_t vt[8];
  int   s, de, t0, seen;

  initial begin
    bus.port_in = '0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.pass_mask = '0; bus.pass_value = '0; bus.fail_mask = '0; bus.fail_value = '0;

    vt[0] = '{24'h010000, 24'h010000, 24'h0,      24'h0,      24'h010000, RES_PASS,    0, 4};
    vt[1] = '{24'h010000, 24'h010000, 24'h0,      24'h0,      24'h000000, RES_TIMEOUT, 0, 1000};
    vt[2] = '{24'h0,      24'h0,      24'h000002, 24'h000002, 24'h000002, RES_FAIL,    0, 1};
    vt[3] = '{24'h0,      24'h0,      24'h010002, 24'h010002, 24'h010002, RES_FAIL,    0, 1};
    vt[4] = '{24'h0,      24'h0,      24'h010002, 24'h010002, 24'h010000, RES_FAIL,    2, 1};
    vt[5] = '{24'h010000, 24'h010000, 24'h000002, 24'h000002, 24'h010002, RES_FAIL,    0, 1};
    vt[6] = '{24'h0,      24'h0,      24'h0,      24'h0,      24'ha5a5a5, RES_PASS,    0, 4};
    vt[7] = '{24'h000080, 24'h000080, 24'h0,      24'h000202, 24'h000282, RES_PASS,    0, 4};

    // Reset values
    tick(); tick();
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst irq", 64'(bus.irq), 64'd0);
    chk("rst result", 64'(bus.result), 64'(RES_NONE));
    chk("rst elapsed", 64'(bus.elapsed), 64'd0);
    chk("rst fail_port", 64'(bus.fail_port), 64'd0);
    @(negedge HCLK) HRESETn = 1'b1;
    tick(); tick();

    // Directed table with pins settled before start
    foreach (vt[i]) begin
      bus.port_in = vt[i].pins;
      tick(); tick(); tick();
      do_start(vt[i].pm, vt[i].pv, vt[i].fm, vt[i].fv, s);
      chk($sformatf("vec%0d busy", i), 64'(bus.busy), 64'd1);
      chk($sformatf("vec%0d elapsed0", i), 64'(bus.elapsed), 64'd0);
      wait_check($sformatf("vec%0d", i), s, vt[i].pm, vt[i].pv, vt[i].fm, vt[i].fv, 1'b0, de);
      chk($sformatf("vec%0d table_res", i), 64'(bus.result), 64'(vt[i].res));
      chk($sformatf("vec%0d table_lat", i), 64'(de - s), 64'(vt[i].lat));
      if (vt[i].res == RES_FAIL)
        chk($sformatf("vec%0d table_fp", i), 64'(bus.fail_port), 64'(vt[i].fp));
    end

    // Pin rises after start: verdict at t0+1+HOLD
    bus.port_in = '0; tick(); tick(); tick();
    do_start(24'h010000, 24'h010000, 24'h0, 24'h0, s);
    tick(); tick(); tick();
    bus.port_in = 24'h010000; t0 = ecnt;
    wait_check("late_pass", s, 24'h010000, 24'h010000, 24'h0, 24'h0, 1'b0, de);
    chk("late_pass edge", 64'(de), 64'(t0 + 5));
    chk("late_pass res", 64'(bus.result), 64'(RES_PASS));

    // Glitch: three synchronized samples only, then timeout
    bus.port_in = '0; tick(); tick(); tick();
    do_start(24'h010000, 24'h010000, 24'h0, 24'h0, s);
    tick(); tick();
    bus.port_in = 24'h010000;
    tick(); tick(); tick();
    bus.port_in = '0;
    wait_check("glitch", s, 24'h010000, 24'h010000, 24'h0, 24'h0, 1'b0, de);
    chk("glitch res", 64'(bus.result), 64'(RES_TIMEOUT));
    chk("glitch edge", 64'(de), 64'(s + int'(TMO)));
    chk("glitch elapsed", 64'(bus.elapsed), 64'(TMO));

    // Fail first true on the edge of the 4th pass sample
    bus.port_in = '0; tick(); tick(); tick();
    do_start(24'h010000, 24'h010000, 24'h000002, 24'h000002, s);
    tick(); tick();
    bus.port_in = 24'h010000; t0 = ecnt;
    tick(); tick(); tick();
    bus.port_in = 24'h010002;
    wait_check("prio", s, 24'h010000, 24'h010000, 24'h000002, 24'h000002, 1'b0, de);
    chk("prio edge", 64'(de), 64'(t0 + 5));
    chk("prio res", 64'(bus.result), 64'(RES_FAIL));
    chk("prio fp", 64'(bus.fail_port), 64'd0);

    // start during HOLD with new patterns is ignored
    bus.port_in = 24'h010000; tick(); tick(); tick();
    do_start(24'h010000, 24'h010000, 24'h0, 24'h0, s);
    tick();
    bus.pass_mask = 24'h000001; bus.pass_value = 24'h000001;
    bus.fail_mask = 24'h010000; bus.fail_value = 24'h010000;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_check("restart_busy", s, 24'h010000, 24'h010000, 24'h0, 24'h0, 1'b0, de);
    chk("restart_busy res", 64'(bus.result), 64'(RES_PASS));
    chk("restart_busy edge", 64'(de), 64'(s + 4));

    // abort mid-HOLD
    do_start(24'h010000, 24'h010000, 24'h0, 24'h0, s);
    tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort result", 64'(bus.result), 64'(RES_NONE));
    chk("abort elapsed", 64'(bus.elapsed), 64'd0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin tick(); seen += int'(bus.done) + int'(bus.irq); end
    chk("abort no_verdict", 64'(seen), 64'd0);
    bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_beats_start busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-HOLD
    do_start(24'h010000, 24'h010000, 24'h0, 24'h0, s);
    tick(); tick();
    #2 HRESETn = 1'b0;
    #1;
    chk("areset busy", 64'(bus.busy), 64'd0);
    chk("areset elapsed", 64'(bus.elapsed), 64'd0);
    chk("areset result", 64'(bus.result), 64'(RES_NONE));
    @(negedge HCLK) HRESETn = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin tick(); seen += int'(bus.done) + int'(bus.irq) + int'(bus.busy); end
    chk("areset no_verdict", 64'(seen), 64'd0);

    // Randomized runs against the reference model
    for (int r = 0; r < 20; r++) begin
      logic [BW-1:0] pm, pv, fm, fv;
      pm = '0; pv = '0; fm = '0; fv = '0;
      for (int p = 0; p < int'(NP); p++) begin
        pm[p*W +: W] = W'($urandom_range(3));
        pv[p*W +: W] = W'($urandom_range(3)) & pm[p*W +: W];
        if ($urandom_range(2) == 0) begin
          fm[p*W +: W] = W'($urandom_range(3, 1));
          fv[p*W +: W] = W'($urandom_range(3));
        end
      end
      bus.port_in = rnd_pins(bus.port_in); tick();
      bus.port_in = rnd_pins(bus.port_in); tick();
      bus.port_in = rnd_pins(bus.port_in); tick();
      do_start(pm, pv, fm, fv, s);
      wait_check($sformatf("rnd%0d", r), s, pm, pv, fm, fv, 1'b1, de);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_monitor.md
# gpio_pattern_monitor

Synthesizable, parametrised monitor that watches NPORTS GPIO ports for a pass pattern held for a minimum number of cycles, a fail pattern, or a timeout, and reports a latched verdict. It sits on the SoC GPIO pad side, in parallel with the GPIO IP inputs. It gives SoC simulation and FPGA bring-up one self-checking end-of-test mechanism, generalising the fixed "bit pattern on port C, fixed timeout" check to any port count, width, mask and debounce length.

## Interface
- NPORTS, 3, number of monitored ports (1..8)
- WIDTH, 32, bits per port
- HOLD_CYCLES, 4, consecutive matching synchronized samples required for pass (>=1)
- TIMEOUT_CYCLES, 100000, cycles after start before timeout verdict (> HOLD_CYCLES)
- CNT_W, 32, width of the elapsed counter (must hold TIMEOUT_CYCLES)

- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- port_in  in  NPORTS*WIDTH  raw pad values, port p at [p*WIDTH +: WIDTH], asynchronous to HCLK
- start  in  1  arm pulse; accepted in IDLE or DONE
- abort  in  1  return to IDLE, verdict cleared
- pass_mask / pass_value  in  NPORTS*WIDTH each  pass pattern, latched at start
- fail_mask / fail_value  in  NPORTS*WIDTH each  fail pattern, latched at start
- busy  out  1  high in ARMED or HOLD
- done  out  1  high in DONE
- irq  out  1  one-cycle pulse on entry to DONE
- result  out  2  verdict code (package enum)
- fail_port  out  max(1,$clog2(NPORTS))  lowest failing port index, valid when result=FAIL
- elapsed  out  CNT_W  cycles since start, frozen in DONE

## Operation
- Each port_in bit passes through a 2-flop synchronizer. All matching uses the synchronized value s.
- Pass condition: for every port p, ((s_p ^ pass_value_p) & pass_mask_p) == 0. A port with a zero mask is trivially satisfied.
- Fail condition: any port p with fail_mask_p != 0 and ((s_p ^ fail_value_p) & fail_mask_p) == 0. Zero-mask ports never fail.
- States: IDLE, ARMED, HOLD, DONE.
- IDLE: start -> ARMED. Latch masks and values, clear elapsed, hold_cnt and result.
- ARMED / HOLD:
  - elapsed increments every edge.
  - Pass true: hold_cnt increments.
  - Pass false: hold_cnt clears and the FSM returns to ARMED.
  - State is HOLD while hold_cnt > 0.
- Terminating events are evaluated on the same edge, priority FAIL > PASS > TIMEOUT:
  - FAIL: fail condition true.
  - PASS: hold_cnt would reach HOLD_CYCLES.
  - TIMEOUT: elapsed would reach TIMEOUT_CYCLES.
  - On any terminating event: -> DONE, result set, irq pulses.
- DONE: outputs held. start -> ARMED (fresh run). Other inputs ignored.
- start while busy: ignored; latched patterns unchanged.
- abort (any state) -> IDLE, result NONE, elapsed cleared. abort beats start on the same edge.
- fail_port: lowest matching index, registered with result.

## Timing
- Reset values: state IDLE, busy 0, done 0, irq 0, result NONE, fail_port 0, elapsed 0, synchronizers 0.
- Start accepted at edge s: busy=1 after s, elapsed=0. The first pattern evaluation uses synchronizer contents at s.
- Pin stable before edge t0: synchronized at t0+1. Counted as hold sample 1 at t0+2.
- PASS verdict: registered at edge t0+1+HOLD_CYCLES.
- FAIL verdict: registered at edge t0+2.
- TIMEOUT: DONE entered at edge s+TIMEOUT_CYCLES, elapsed=TIMEOUT_CYCLES.
- irq: high exactly one cycle, the first DONE cycle.
- Asynchronous reset mid-run: immediate return to reset values. No verdict survives.

## Structure
- Package gpio_mon_pkg: result enum RES_NONE=0, RES_PASS=1, RES_FAIL=2, RES_TIMEOUT=3; state enum; localparam for the fail_port width.
- One sub-module, gpio_mon_sync: parametrised-width 2-flop synchronizer with async active-low reset, instantiated once over NPORTS*WIDTH bits.
- Pattern compare is a combinational generate loop over ports inside the top.

## Test plan
- Pass:
  - Setup: NPORTS=3, HOLD=4, TIMEOUT=1000; pass_mask port2=0x1, value 0x1; fail masks 0.
  - Stimulus: drive port2[0]=1 before edge t0.
  - Required: result=PASS, irq at t0+5, elapsed frozen.
- Glitch rejection:
  - Stimulus: port2[0] high for 3 synchronized cycles, then low forever.
  - Required: no pass; result=TIMEOUT at s+1000, elapsed=1000.
- Priority:
  - Setup: fail_mask port0=0x2, value 0x2.
  - Stimulus: port0[1] rises so its fail condition is first true on the same edge the 4th pass sample completes.
  - Required: result=FAIL, fail_port=0.
- fail_port index:
  - Setup: fail patterns armed on ports 0 and 2.
  - Stimulus: both match on the same cycle.
  - Required: fail_port=0. Repeat with only port 2 matching: fail_port=2.
- Control:
  - start pulsed during HOLD with new masks: ignored, verdict uses the old masks.
  - abort mid-HOLD: IDLE, result NONE.
  - start from DONE: new run, elapsed restarts at 0.
- Reset:
  - Stimulus: assert HRESETn low asynchronously mid-HOLD.
  - Required: all outputs zero before the next edge, no irq after release.
